// File: rtl/aes_pkg.sv
// Shared definitions for the AES encipher arbiter slice: key length codes and
// the control FSM state encoding.
package aes_pkg;

    localparam logic AES_128_BIT_KEY = 1'b0;
    localparam logic AES_256_BIT_KEY = 1'b1;

    typedef enum logic [2:0] {
        CTRL_IDLE,
        CTRL_CHECK,
        CTRL_KEY_START,
        CTRL_KEY_WAIT,
        CTRL_ENC_START,
        CTRL_ENC_WAIT
    } ctrl_state_t;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that did not win
// last time is granted; rr_last resets to 1 so requester 0 wins first.
module aes_rr_arb2 (
    input  logic clk,
    input  logic reset_n,
    input  logic req0,
    input  logic req1,
    input  logic update,
    output logic grant_id
);

    logic rr_last;

    assign grant_id = (req0 && req1) ? !rr_last : req1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last <= 1'b1;
        end else if (update) begin
            rr_last <= grant_id;
        end
    end

endmodule

// File: rtl/aes_encipher_arbiter.sv
// Shares one encipher block and its key memory between two requesters, reloading
// the key memory only when the requested key differs from the one already expanded.
module aes_encipher_arbiter
    import aes_pkg::*;
#(
    parameter bit FORCE_KEY_INIT = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_block,
    input  logic [255:0] req0_key,
    input  logic         req0_keylen,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_block,
    input  logic [255:0] req1_key,
    input  logic         req1_keylen,
    output logic         resp0_valid,
    input  logic         resp0_ready,
    output logic         resp1_valid,
    input  logic         resp1_ready,
    output logic [127:0] resp_data,
    input  logic         key_flush,
    output logic         km_init,
    output logic [255:0] km_key,
    output logic         km_keylen,
    input  logic         km_ready,
    output logic         enc_next,
    output logic [127:0] enc_block,
    input  logic [127:0] enc_new_block,
    input  logic         enc_ready,
    output logic         busy
);

    ctrl_state_t  state;
    ctrl_state_t  state_next;
    logic         accept;
    logic         grant_id;
    logic         cap_id;
    logic [255:0] loaded_key;
    logic         loaded_keylen;
    logic         key_vld;
    logic         key_hit;

    // Accepting is blocked while a response is pending so resp_data stays put.
    assign accept = (state == CTRL_IDLE) && enc_ready && km_ready &&
                    !resp0_valid && !resp1_valid && (req0_valid || req1_valid);

    aes_rr_arb2 u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .req0     (req0_valid),
        .req1     (req1_valid),
        .update   (accept),
        .grant_id (grant_id)
    );

    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;
    assign busy       = (state != CTRL_IDLE);

    assign key_hit = key_vld && (km_key == loaded_key) &&
                     (km_keylen == loaded_keylen) && !FORCE_KEY_INIT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CTRL_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        km_init    = 1'b0;
        enc_next   = 1'b0;
        case (state)
            CTRL_IDLE: begin
                if (accept) begin
                    state_next = CTRL_CHECK;
                end
            end
            CTRL_CHECK: begin
                state_next = key_hit ? CTRL_ENC_START : CTRL_KEY_START;
            end
            CTRL_KEY_START: begin
                km_init    = 1'b1;
                state_next = CTRL_KEY_WAIT;
            end
            CTRL_KEY_WAIT: begin
                if (km_ready) begin
                    state_next = CTRL_ENC_START;
                end
            end
            CTRL_ENC_START: begin
                enc_next   = 1'b1;
                state_next = CTRL_ENC_WAIT;
            end
            CTRL_ENC_WAIT: begin
                if (enc_ready) begin
                    state_next = CTRL_IDLE;
                end
            end
            default: begin
                state_next = CTRL_IDLE;
            end
        endcase
    end

    // The captured request doubles as the registered key-memory/cipher operands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_id    <= 1'b0;
            enc_block <= '0;
            km_key    <= '0;
            km_keylen <= AES_128_BIT_KEY;
        end else if (accept) begin
            cap_id    <= grant_id;
            enc_block <= grant_id ? req1_block  : req0_block;
            km_key    <= grant_id ? req1_key    : req0_key;
            km_keylen <= grant_id ? req1_keylen : req0_keylen;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loaded_key    <= '0;
            loaded_keylen <= AES_128_BIT_KEY;
            key_vld       <= 1'b0;
        end else if ((state == CTRL_KEY_WAIT) && km_ready) begin
            loaded_key    <= km_key;
            loaded_keylen <= km_keylen;
            key_vld       <= !key_flush;
        end else if ((state == CTRL_KEY_START) || key_flush) begin
            key_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_data   <= '0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
        end else begin
            if (resp0_valid && resp0_ready) begin
                resp0_valid <= 1'b0;
            end
            if (resp1_valid && resp1_ready) begin
                resp1_valid <= 1'b0;
            end
            if ((state == CTRL_ENC_WAIT) && enc_ready) begin
                resp_data <= enc_new_block;
                if (cap_id) begin
                    resp1_valid <= 1'b1;
                end else begin
                    resp0_valid <= 1'b1;
                end
            end
        end
    end

endmodule
